lieat_axi_rd_arbiter: RTL and testbench
=======================================

Name: lieat_axi_rd_arbiter

Overview:
- Two-master to one-slave AXI read arbiter. It sits directly upstream of the SRAM AXI slave.
- Masters are the IFU (fetch, id 0) and the LSU (load, id 1).
- It multiplexes their AR requests onto one slave AR channel and routes the single R response back to the requester.
- Only one read is outstanding at a time, matching the slave's single-outstanding read handshake.
- Write channels do not pass through this block.

Parameters:
- AW, 32, address width (equals `XLEN).
- DW, 64, read data width (equals `XLEN*2).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset.
- ifu_arvalid  in  1  IFU read request valid.
- ifu_arready  out  1  IFU request accepted.
- ifu_araddr  in  AW  IFU read address.
- ifu_arsize  in  3  IFU AXI size code (0..3 = 1/2/4/8 bytes).
- ifu_rvalid  out  1  IFU response valid.
- ifu_rready  in  1  IFU response ready.
- ifu_rdata  out  DW  IFU response data.
- lsu_arvalid  in  1  LSU read request valid.
- lsu_arready  out  1  LSU request accepted.
- lsu_araddr  in  AW  LSU read address.
- lsu_arsize  in  3  LSU AXI size code.
- lsu_rvalid  out  1  LSU response valid.
- lsu_rready  in  1  LSU response ready.
- lsu_rdata  out  DW  LSU response data.
- m_axi_arvalid  out  1  slave AR valid.
- m_axi_arready  in  1  slave AR ready.
- m_axi_araddr  out  AW  slave AR address (registered).
- m_axi_arsize  out  3  slave AR size (registered).
- m_axi_arid  out  4  slave AR id: 4'd0 = IFU, 4'd1 = LSU.
- m_axi_rvalid  in  1  slave R valid.
- m_axi_rready  out  1  slave R ready.
- m_axi_rdata  in  DW  slave R data.
- m_axi_rid  in  4  slave R id.
- rid_err  out  1  sticky flag: response id mismatched the outstanding id.

Behaviour:
- FSM states: IDLE, REQ, RESP. State resets asynchronously (reset=0) to IDLE.
- Reset values:
  - m_axi_arvalid=0, m_axi_rready=0, ifu_rvalid=0, lsu_rvalid=0, rid_err=0.
  - Address, size and id registers reset to 0.
  - last_grant resets to LSU.
- IDLE:
  - Grant is combinational from the current arvalids.
  - ifu_arready = IDLE & grant_ifu; lsu_arready = IDLE & grant_lsu. A non-granted master sees arready=0.
  - On the granted master's handshake, latch its addr, size and id (IFU=0, LSU=1) and go to REQ.
  - With no request, stay in IDLE; both arready are driven for whichever master would win. With no requester, grant defaults to LSU.
- REQ:
  - m_axi_arvalid=1; araddr, arsize and arid are held stable from the registers.
  - On m_axi_arvalid & m_axi_arready, go to RESP.
  - No master arready is asserted in REQ or RESP.
- RESP:
  - m_axi_rready = rready of the latched master. Only that master's rvalid = m_axi_rvalid; the other is 0.
  - ifu_rdata and lsu_rdata both = m_axi_rdata combinationally (zero added latency).
  - On the R handshake, go to IDLE. A new request is accepted no earlier than the cycle after the R handshake.
- Latency: master AR handshake in cycle N gives m_axi_arvalid high in cycle N+1. Minimum request-to-request spacing is 3 cycles plus slave latency.
- Routing uses the latched id, never m_axi_rid.
  - If m_axi_rvalid is high in RESP and m_axi_rid differs from the latched id, rid_err sets and stays set until reset.
  - Routing is still performed by the latched id.
- m_axi_rvalid asserted in IDLE or REQ is ignored: not forwarded, rready=0.
- Backpressure: a master holding rready=0 stalls RESP indefinitely. The other master waits with arready=0.
- Reset mid-operation: FSM returns to IDLE and all valids drop immediately (asynchronous). Any in-flight response is discarded; the slave shares the same reset.
- Mutually exclusive outputs: ifu_rvalid and lsu_rvalid are never both 1. ifu_arready and lsu_arready are never both 1.

Optional Feature:
- Macro LIEAT_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests in IDLE, grant the master not equal to last_grant.
  - last_grant updates on every AR handshake with a master.
  - After reset the first tie goes to IFU.
- Undefined: fixed priority, LSU wins every tie. The last_grant flop is not built.

Test Plan:
1. Only ifu_arvalid=1, addr 0x80000000, size 2, slave returns 0x1122334455667788 → ifu_arready in cycle 0; m_axi_arvalid cycle 1 with arid=0, size=2; ifu_rvalid with data 0x1122334455667788; lsu_rvalid stays 0.
2. Both request in the same cycle (IFU 0x80000000, LSU 0x80001000), with LIEAT_ARB_RR_EN defined → first grant IFU (arid=0), then LSU (arid=1). Without the macro, LSU goes first. Both responses are delivered in order.
3. LSU request granted, lsu_rready held 0 for 5 cycles after m_axi_rvalid → m_axi_rready=0 throughout; ifu_arready=0 throughout; completes on the cycle lsu_rready=1.
4. Slave returns rid=1 for an IFU request → data routed to IFU; rid_err=1 and stays 1 until reset.
5. Reset asserted while in RESP with m_axi_rvalid=1 → all valids are 0 at once. After release: IDLE, rid_err=0, next request accepted normally.
6. m_axi_arready held 0 for 4 cycles in REQ → araddr, arsize and arid stay constant; no master arready.

Source files
------------

// File: rtl/lieat_axi_rd_arbiter.sv
//------------------------------------------------------------------------------
// Module   : lieat_axi_rd_arbiter
// Purpose  : Two-master (IFU id 0, LSU id 1) to one-slave AXI read arbiter,
//            single outstanding read. Define LIEAT_ARB_RR_EN for round-robin
//            tie-breaking; otherwise LSU wins every tie.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lieat_axi_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ifu_arvalid,
  output logic          ifu_arready,
  input  logic [AW-1:0] ifu_araddr,
  input  logic [2:0]    ifu_arsize,
  output logic          ifu_rvalid,
  input  logic          ifu_rready,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_arvalid,
  output logic          lsu_arready,
  input  logic [AW-1:0] lsu_araddr,
  input  logic [2:0]    lsu_arsize,
  output logic          lsu_rvalid,
  input  logic          lsu_rready,
  output logic [DW-1:0] lsu_rdata,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  output logic [AW-1:0] m_axi_araddr,
  output logic [2:0]    m_axi_arsize,
  output logic [3:0]    m_axi_arid,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready,
  input  logic [DW-1:0] m_axi_rdata,
  input  logic [3:0]    m_axi_rid,
  output logic          rid_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant_lsu;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_sel_lsu;
  logic          w_idle;
  logic          w_resp;
  logic [AW-1:0] r_araddr;
  logic [2:0]    r_arsize;
  logic [3:0]    r_arid;
  logic          r_rid_err;

`ifdef LIEAT_ARB_RR_EN
  logic r_last_grant_lsu;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant_lsu <= 1'b1;
    end else if (w_ar_hs) begin
      r_last_grant_lsu <= w_grant_lsu;
    end
  end

  // On a tie, the master that did not win last time gets the grant
  always_comb begin
    w_grant_lsu = ~ifu_arvalid;
    if (ifu_arvalid && lsu_arvalid) begin
      w_grant_lsu = ~r_last_grant_lsu;
    end
  end
`else
  assign w_grant_lsu = lsu_arvalid | ~ifu_arvalid;
`endif

  assign w_idle      = (r_state == IDLE);
  assign w_resp      = (r_state == RESP);
  assign ifu_arready = w_idle & ~w_grant_lsu;
  assign lsu_arready = w_idle &  w_grant_lsu;
  assign w_ar_hs     = (ifu_arvalid & ifu_arready) | (lsu_arvalid & lsu_arready);

  // Response routing follows the latched id, never the returned rid
  assign w_sel_lsu     = r_arid[0];
  assign m_axi_arvalid = (r_state == REQ);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arid    = r_arid;
  assign m_axi_rready  = w_resp & (w_sel_lsu ? lsu_rready : ifu_rready);
  assign ifu_rvalid    = w_resp & ~w_sel_lsu & m_axi_rvalid;
  assign lsu_rvalid    = w_resp &  w_sel_lsu & m_axi_rvalid;
  assign ifu_rdata     = m_axi_rdata;
  assign lsu_rdata     = m_axi_rdata;
  assign w_r_hs        = m_axi_rvalid & m_axi_rready;
  assign rid_err       = r_rid_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ar_hs) w_state_nxt = REQ;
      REQ:     if (m_axi_arready) w_state_nxt = RESP;
      RESP:    if (w_r_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_araddr  <= '0;
      r_arsize  <= '0;
      r_arid    <= '0;
      r_rid_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ar_hs) begin
        r_araddr <= w_grant_lsu ? lsu_araddr : ifu_araddr;
        r_arsize <= w_grant_lsu ? lsu_arsize : ifu_arsize;
        r_arid   <= {3'b000, w_grant_lsu};
      end
      if (w_resp && m_axi_rvalid && (m_axi_rid != r_arid)) begin
        r_rid_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lieat_axi_rd_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_lieat_axi_rd_arbiter
// Purpose  : Directed self-checking bench for lieat_axi_rd_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lieat_axi_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr;
  logic [2:0]  ifu_arsize;
  logic [63:0] ifu_rdata;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic [63:0] lsu_rdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize;
  logic [3:0]  m_axi_arid, m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic        rid_err;

  int n_checks = 0;
  int n_errors = 0;
  logic first_lsu;

  always #5 clock = ~clock;

  lieat_axi_rd_arbiter #(.AW(32), .DW(64)) u_dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize), .m_axi_arid(m_axi_arid),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .rid_err(rid_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later
  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_arsize = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rid = '0;
    step(); step(); settle();
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_ifu_rvalid", ifu_rvalid, 0);
    chk("rst_lsu_rvalid", lsu_rvalid, 0);
    chk("rst_rid_err", rid_err, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arid", m_axi_arid, 0);
    step(); reset = 1'b1;

    // Simultaneous requests straight after reset
`ifdef LIEAT_ARB_RR_EN
    first_lsu = 1'b0;
`else
    first_lsu = 1'b1;
`endif
    step();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arsize = 3'd2;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_1000; lsu_arsize = 3'd3;
    ifu_rready = 1; lsu_rready = 1;
    settle();
    chk("tie_ifu_arready", ifu_arready, !first_lsu);
    chk("tie_lsu_arready", lsu_arready, first_lsu);
    for (int k = 0; k < 2; k++) begin
      logic cur_lsu;
      cur_lsu = (k == 0) ? first_lsu : !first_lsu;
      step();
      if (cur_lsu) lsu_arvalid = 0; else ifu_arvalid = 0;
      m_axi_arready = 1;
      settle();
      chk("tie_arvalid", m_axi_arvalid, 1);
      chk("tie_arid", m_axi_arid, {3'b0, cur_lsu});
      chk("tie_araddr", m_axi_araddr, cur_lsu ? 32'h8000_1000 : 32'h8000_0000);
      chk("tie_no_arready", {ifu_arready, lsu_arready}, 0);
      step();
      m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rid = {3'b0, cur_lsu};
      m_axi_rdata = cur_lsu ? 64'hAAAA_0000_0000_0001 : 64'hBBBB_0000_0000_0002;
      settle();
      chk("tie_ifu_rvalid", ifu_rvalid, !cur_lsu);
      chk("tie_lsu_rvalid", lsu_rvalid, cur_lsu);
      chk("tie_rdata", cur_lsu ? lsu_rdata : ifu_rdata, m_axi_rdata);
      chk("tie_rready", m_axi_rready, 1);
      if (k == 0) begin
        step(); m_axi_rvalid = 0; settle();
        chk("tie_second_arready", cur_lsu ? ifu_arready : lsu_arready, 1);
      end
    end
    step(); m_axi_rvalid = 0; settle();
    chk("tie_idle_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
    chk("tie_rid_err", rid_err, 0);

    // Plain IFU read
    step();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arsize = 3'd2;
    settle();
    chk("t1_ifu_arready", ifu_arready, 1);
    chk("t1_lsu_arready", lsu_arready, 0);
    step(); ifu_arvalid = 0; m_axi_arready = 1; settle();
    chk("t1_arvalid", m_axi_arvalid, 1);
    chk("t1_arid", m_axi_arid, 0);
    chk("t1_arsize", m_axi_arsize, 2);
    chk("t1_araddr", m_axi_araddr, 32'h8000_0000);
    step(); m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rid = 0;
    m_axi_rdata = 64'h1122_3344_5566_7788; settle();
    chk("t1_ifu_rvalid", ifu_rvalid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 64'h1122_3344_5566_7788);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    step(); m_axi_rvalid = 0; settle();
    chk("t1_done_ifu_rvalid", ifu_rvalid, 0);

    // LSU read with response backpressure; IFU waits meanwhile
    step();
    lsu_arvalid = 1; lsu_araddr = 32'h8000_2000; lsu_arsize = 3'd3; settle();
    chk("t3_lsu_arready", lsu_arready, 1);
    step(); lsu_arvalid = 0; m_axi_arready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0040; ifu_arsize = 3'd1; settle();
    chk("t3_arid", m_axi_arid, 1);
    step(); m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rid = 1; lsu_rready = 0;
    m_axi_rdata = 64'hCAFE_F00D_0000_0003;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t3_stall_rready", m_axi_rready, 0);
      chk("t3_stall_ifu_arready", ifu_arready, 0);
      chk("t3_stall_lsu_rvalid", lsu_rvalid, 1);
      step();
    end
    lsu_rready = 1; settle();
    chk("t3_rready", m_axi_rready, 1);
    chk("t3_lsu_rdata", lsu_rdata, 64'hCAFE_F00D_0000_0003);
    chk("t3_ifu_rvalid", ifu_rvalid, 0);
    step(); m_axi_rvalid = 0; settle();
    chk("t3_ifu_accept", ifu_arready, 1);

    // Slave AR stall; stray rvalid in REQ is ignored
    step(); ifu_arvalid = 0; m_axi_rvalid = 1; m_axi_rid = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t6_arvalid", m_axi_arvalid, 1);
      chk("t6_araddr", m_axi_araddr, 32'h8000_0040);
      chk("t6_arsize", m_axi_arsize, 1);
      chk("t6_arid", m_axi_arid, 0);
      chk("t6_no_arready", {ifu_arready, lsu_arready}, 0);
      chk("t6_ignored_r", {ifu_rvalid, lsu_rvalid, m_axi_rready}, 0);
      step();
    end
    m_axi_rvalid = 0; m_axi_arready = 1;
    step(); m_axi_arready = 0;

    // Wrong rid on an IFU response
    m_axi_rvalid = 1; m_axi_rid = 1; m_axi_rdata = 64'h0BAD_0000_0000_0004; settle();
    chk("t4_ifu_rvalid", ifu_rvalid, 1);
    chk("t4_lsu_rvalid", lsu_rvalid, 0);
    chk("t4_ifu_rdata", ifu_rdata, 64'h0BAD_0000_0000_0004);
    step(); m_axi_rvalid = 0; m_axi_rid = 0; settle();
    chk("t4_rid_err", rid_err, 1);
    step(); step(); settle();
    chk("t4_rid_err_sticky", rid_err, 1);

    // Asynchronous reset while a response is pending
    step(); lsu_arvalid = 1; lsu_araddr = 32'h8000_3000; lsu_arsize = 3'd0;
    step(); lsu_arvalid = 0; m_axi_arready = 1;
    step(); m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rid = 1; lsu_rready = 0; settle();
    chk("t5_pre_lsu_rvalid", lsu_rvalid, 1);
    reset = 1'b0; settle();
    chk("t5_lsu_rvalid", lsu_rvalid, 0);
    chk("t5_ifu_rvalid", ifu_rvalid, 0);
    chk("t5_arvalid", m_axi_arvalid, 0);
    chk("t5_rready", m_axi_rready, 0);
    chk("t5_rid_err", rid_err, 0);
    step(); m_axi_rvalid = 0; reset = 1'b1;
    step(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0080; ifu_arsize = 3'd2; settle();
    chk("t5_post_ifu_arready", ifu_arready, 1);
    step(); ifu_arvalid = 0; settle();
    chk("t5_post_arvalid", m_axi_arvalid, 1);
    chk("t5_post_araddr", m_axi_araddr, 32'h8000_0080);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
